// File: rtl/lbist_pkg.sv
// Shared types and default cycle counts for the LBIST sequencer and its bench.
package lbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } lbist_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_TEST_CYCLES   = 4096;
  localparam int unsigned DEF_SETTLE_CYCLES = 8;
  localparam int unsigned DEF_CHECK_CYCLES  = 4;
  localparam int unsigned DEF_CNT_WIDTH     = 16;
  localparam int unsigned RUN_COUNT_W       = 8;

  // Completed-run counter holds at all-ones instead of wrapping.
  function automatic logic [RUN_COUNT_W-1:0] sat_inc(input logic [RUN_COUNT_W-1:0] v);
    logic [RUN_COUNT_W-1:0] r;
    r = (v == {RUN_COUNT_W{1'b1}}) ? v : v + RUN_COUNT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/lbist_sequencer.sv
// LBIST sequencer: walks the core wrapper through reset, self-test, settle and
// check phases, then reports a sticky verdict and gates functional fetch.
module lbist_sequencer
  import lbist_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned TEST_CYCLES   = DEF_TEST_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CHECK_CYCLES  = DEF_CHECK_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   go_nogo_i,
  output logic                   dut_rst_o,
  output logic                   test_mode_o,
  output logic                   fetch_enable_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   fail_o,
  output logic [RUN_COUNT_W-1:0] run_count_o
);

  // Each timed state counts down from N-1 and exits on the cycle it reads 0.
  localparam logic [CNT_WIDTH-1:0] RST_LOAD    = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TEST_LOAD   = CNT_WIDTH'(TEST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CHECK_LOAD  = CNT_WIDTH'(CHECK_CYCLES - 1);

  lbist_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   fail_flag_q, fail_flag_d;
  logic [RUN_COUNT_W-1:0] run_count_q, run_count_d;

  logic dut_rst_q, dut_rst_d;
  logic test_mode_q, test_mode_d;
  logic fetch_enable_q, fetch_enable_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic fail_q, fail_d;

  logic cnt_zero;
  assign cnt_zero = (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      fail_flag_q    <= 1'b0;
      run_count_q    <= '0;
      dut_rst_q      <= 1'b1;
      test_mode_q    <= 1'b0;
      fetch_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fail_flag_q    <= fail_flag_d;
      run_count_q    <= run_count_d;
      dut_rst_q      <= dut_rst_d;
      test_mode_q    <= test_mode_d;
      fetch_enable_q <= fetch_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
    end
  end

  // Next-state and phase counter; abort always wins over start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!abort_i && start_i) begin
          state_d = ST_RESET;
          cnt_d   = RST_LOAD;
        end
      end
      ST_RESET: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_RUN;
          cnt_d   = TEST_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_CHECK;
          cnt_d   = CHECK_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_CHECK: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d = ST_RESET;
          cnt_d   = RST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Verdict and run counter; go_nogo only matters while in CHECK
  always_comb begin
    fail_flag_d = fail_flag_q;
    run_count_d = run_count_q;
    if (state_d == ST_RESET && state_q != ST_RESET) begin
      fail_flag_d = 1'b0;
    end
    if (state_q == ST_CHECK && !go_nogo_i) begin
      fail_flag_d = 1'b1;
    end
    if (state_d == ST_IDLE) begin
      fail_flag_d = 1'b0;
    end
    if (state_q == ST_CHECK && state_d == ST_DONE) begin
      run_count_d = sat_inc(run_count_q);
    end
  end

  // Output decode from the upcoming state so outputs register alongside it
  always_comb begin
    dut_rst_d      = 1'b0;
    test_mode_d    = 1'b0;
    fetch_enable_d = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    pass_d         = 1'b0;
    fail_d         = 1'b0;
    case (state_d)
      ST_IDLE: begin
        dut_rst_d = 1'b1;
      end
      ST_RESET: begin
        dut_rst_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_RUN, ST_SETTLE, ST_CHECK: begin
        test_mode_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_DONE: begin
        done_d         = 1'b1;
        pass_d         = !fail_flag_d;
        fail_d         = fail_flag_d;
        fetch_enable_d = !fail_flag_d;
        dut_rst_d      = fail_flag_d;
      end
      default: begin
        dut_rst_d = 1'b1;
      end
    endcase
  end

  assign dut_rst_o      = dut_rst_q;
  assign test_mode_o    = test_mode_q;
  assign fetch_enable_o = fetch_enable_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign run_count_o    = run_count_q;

endmodule

// File: tb/tb_lbist_sequencer.sv
// Directed bench for lbist_sequencer with short phase lengths (R=2 T=8 S=2 C=3).
module tb_lbist_sequencer;
  import lbist_pkg::*;

  localparam int R = 2;
  localparam int T = 8;
  localparam int S = 2;
  localparam int C = 3;
  localparam int DONE_CYC = R + T + S + C + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic       go_nogo_i;
  logic       dut_rst_o;
  logic       test_mode_o;
  logic       fetch_enable_o;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic       fail_o;
  logic [7:0] run_count_o;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] rc_exp = 8'd0;

  always #5 clk = ~clk;

  lbist_sequencer #(
    .RST_CYCLES   (R),
    .TEST_CYCLES  (T),
    .SETTLE_CYCLES(S),
    .CHECK_CYCLES (C),
    .CNT_WIDTH    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .go_nogo_i     (go_nogo_i),
    .dut_rst_o     (dut_rst_o),
    .test_mode_o   (test_mode_o),
    .fetch_enable_o(fetch_enable_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .run_count_o   (run_count_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // start_i is sampled at the end of cycle 0; on return the bench is in cycle 1
  task automatic begin_run();
    go_nogo_i = 1'b1;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    cyc       = 1;
  endtask

  // go_nogo_i is driven low in cycles lo..hi and in cycle g2
  task automatic run_until(input int upto, input int lo, input int hi, input int g2);
    while (cyc < upto) begin
      go_nogo_i = !((cyc >= lo && cyc <= hi) || cyc == g2);
      tick();
      cyc++;
    end
    go_nogo_i = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    go_nogo_i = 1'b1;

    // 1. Reset
    tick();
    tick();
    chk1("rst_dut_rst", dut_rst_o, 1'b1);
    chk1("rst_test_mode", test_mode_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_fetch", fetch_enable_o, 1'b0);
    chk8("rst_run_count", run_count_o, 8'd0);
    rst = 1'b0;
    tick();
    chk1("idle_dut_rst", dut_rst_o, 1'b1);

    // 2. Passing run, per-cycle phase decode
    begin_run();
    for (int n = 1; n <= DONE_CYC; n++) begin
      cyc = n;
      chk1("pass_test_mode", test_mode_o, (n >= 3 && n <= 15));
      chk1("pass_dut_rst", dut_rst_o, (n <= 2));
      chk1("pass_busy", busy_o, (n <= 15));
      chk1("pass_done", done_o, (n == DONE_CYC));
      if (n < DONE_CYC) tick();
    end
    rc_exp = 8'd1;
    chk1("pass_pass", pass_o, 1'b1);
    chk1("pass_fail", fail_o, 1'b0);
    chk1("pass_fetch", fetch_enable_o, 1'b1);
    chk8("pass_run_count", run_count_o, rc_exp);
    tick();
    cyc++;
    chk1("pass_done_hold", done_o, 1'b1);

    // 3. Failing run restarted from DONE; result clears one cycle after start
    begin_run();
    chk1("restart_done_clr", done_o, 1'b0);
    chk1("restart_pass_clr", pass_o, 1'b0);
    chk1("restart_fetch_clr", fetch_enable_o, 1'b0);
    run_until(DONE_CYC, 14, 14, -1);
    rc_exp = 8'd2;
    chk1("fail_fail", fail_o, 1'b1);
    chk1("fail_pass", pass_o, 1'b0);
    chk1("fail_done", done_o, 1'b1);
    chk1("fail_dut_rst", dut_rst_o, 1'b1);
    chk1("fail_fetch", fetch_enable_o, 1'b0);
    chk8("fail_run_count", run_count_o, rc_exp);

    // 4. go_nogo glitches in RUN and SETTLE are ignored
    begin_run();
    run_until(DONE_CYC, 4, 10, 12);
    rc_exp = 8'd3;
    chk1("glitch_pass", pass_o, 1'b1);
    chk1("glitch_fail", fail_o, 1'b0);
    chk1("glitch_fetch", fetch_enable_o, 1'b1);
    chk8("glitch_run_count", run_count_o, rc_exp);

    // 5. Abort mid-RUN, then start+abort together in IDLE
    begin_run();
    run_until(6, -1, -1, -1);
    chk1("pre_abort_test_mode", test_mode_o, 1'b1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    cyc = 7;
    chk1("abort_busy", busy_o, 1'b0);
    chk1("abort_test_mode", test_mode_o, 1'b0);
    chk1("abort_dut_rst", dut_rst_o, 1'b1);
    chk1("abort_done", done_o, 1'b0);
    chk8("abort_run_count", run_count_o, rc_exp);
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    tick();
    chk1("start_abort_busy", busy_o, 1'b0);
    chk1("start_abort_dut_rst", dut_rst_o, 1'b1);

    // 6. start ignored in RUN; DONE still at cycle 16
    begin_run();
    chk1("idle_start_busy", busy_o, 1'b1);
    run_until(8, -1, -1, -1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 9;
    run_until(DONE_CYC - 1, -1, -1, -1);
    chk1("ignore_start_not_done", done_o, 1'b0);
    chk1("ignore_start_test_mode", test_mode_o, 1'b1);
    run_until(DONE_CYC, -1, -1, -1);
    rc_exp = 8'd4;
    chk1("ignore_start_done", done_o, 1'b1);
    chk1("ignore_start_pass", pass_o, 1'b1);
    chk8("ignore_start_run_count", run_count_o, rc_exp);

    // Abort in DONE returns to IDLE and clears the verdict
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk1("done_abort_done", done_o, 1'b0);
    chk1("done_abort_pass", pass_o, 1'b0);
    chk1("done_abort_fetch", fetch_enable_o, 1'b0);
    chk1("done_abort_dut_rst", dut_rst_o, 1'b1);
    chk8("done_abort_run_count", run_count_o, rc_exp);

    // Reset mid-run clears the run counter
    begin_run();
    run_until(5, -1, -1, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rc_exp = 8'd0;
    chk8("midrun_rst_run_count", run_count_o, rc_exp);
    chk1("midrun_rst_busy", busy_o, 1'b0);
    chk1("midrun_rst_dut_rst", dut_rst_o, 1'b1);
    chk1("midrun_rst_test_mode", test_mode_o, 1'b0);

    // Saturation: back-to-back passing runs
    for (int k = 0; k < 254; k++) begin
      begin_run();
      run_until(DONE_CYC, -1, -1, -1);
    end
    rc_exp = 8'd254;
    chk8("sat_254", run_count_o, rc_exp);
    begin_run();
    run_until(DONE_CYC, -1, -1, -1);
    rc_exp = 8'd255;
    chk8("sat_255", run_count_o, rc_exp);
    begin_run();
    run_until(DONE_CYC, -1, -1, -1);
    chk8("sat_hold", run_count_o, rc_exp);
    chk1("sat_pass", pass_o, 1'b1);
    chk1("sat_excl", pass_o & fail_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
